// File: rtl/mp_pkg.sv
// Shared types for the multi-precision MAC pipeline: mode encodings and stage control.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
// Contents: mode_e/sign_e encodings, mode_t (in_mode layout), stage_ctl_t, decode_mode().
package mp_pkg;

  typedef enum logic {
    MODE_FULL  = 1'b0,  // one W x W product
    MODE_SPLIT = 1'b1   // two independent (W/2) x (W/2) lanes
  } mode_e;

  typedef enum logic {
    SIGN_U = 1'b0,
    SIGN_S = 1'b1
  } sign_e;

  // Field order mirrors in_mode: bit1 = signedness, bit0 = split.
  typedef struct packed {
    sign_e sgn;
    mode_e split;
  } mode_t;

  // Control half of a pipeline stage; the data half is sized by the
  // module parameters and travels in registers alongside it.
  typedef struct packed {
    logic  valid;
    logic  last;
    mode_t mode;
  } stage_ctl_t;

  function automatic mode_t decode_mode(input logic [1:0] m);
    mode_t r;
    r.sgn   = sign_e'(m[1]);
    r.split = mode_e'(m[0]);
    return r;
  endfunction

endpackage

// File: rtl/mp_mac_pipe_if.sv
// Operand-in / result-out handshake bundle for mp_mac_pipe.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the beat input and the result output.
// Ports: in_valid/in_ready/in_x/in_y/in_mode/in_last (beat), out_valid/out_ready/out_acc (result).
interface mp_mac_pipe_if #(
  parameter int W     = 8,
  parameter int ACC_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic [1:0]       in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;

  // Feeder/drain side.
  modport master (
    output in_valid, in_x, in_y, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_acc
  );

  // MAC side.
  modport slave (
    input  in_valid, in_x, in_y, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_acc
  );

endinterface

// File: rtl/mp_hps_mult.sv
// Half-width partial-product multiplier: H x H with per-operand signedness, 2H-bit result.
// Latency: 0 (combinational).
// Backpressure: none; the caller registers the result.
// Ports: a, b (H bits), a_signed, b_signed, p (2H bits, two's complement when either input is signed).
module mp_hps_mult #(
  parameter int H = 4
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  logic           a_signed,
  input  logic           b_signed,
  output logic [2*H-1:0] p
);

  logic [2*H-1:0] a_ext;
  logic [2*H-1:0] b_ext;

  // The low 2H bits of a product only depend on the low 2H bits of its
  // operands, so extending to 2H and multiplying modulo 2^2H gives the
  // exact signed/unsigned product without any wider intermediate.
  assign a_ext = {{H{a_signed & a[H-1]}}, a};
  assign b_ext = {{H{b_signed & b[H-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/mp_mac_pipe.sv
// Pipelined multi-precision MAC: W x W or dual (W/2) x (W/2) products accumulated per in_last group.
// Latency: last beat accepted at edge k -> out_valid after edge k+3; one beat per cycle.
// Backpressure: whole pipe advances on (!out_valid || out_ready); in_ready equals that advance.
// Ports: clk, rst_n (async active-low), bus (mp_mac_pipe_if.slave).
module mp_mac_pipe
  import mp_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mp_mac_pipe_if.slave  bus
);

  localparam int H  = W / 2;
  localparam int HA = ACC_W / 2;

  logic advance;
  logic accept;

  // Group mode tracking
  logic  in_grp_q, in_grp_d;
  mode_t grp_mode_q, grp_mode_d;
  mode_t beat_mode;

  // S1: input register
  stage_ctl_t   s1_ctl_q, s1_ctl_d;
  logic [W-1:0] s1_x_q, s1_x_d;
  logic [W-1:0] s1_y_q, s1_y_d;

  // S2: partial products
  stage_ctl_t           s2_ctl_q, s2_ctl_d;
  logic [3:0][2*H-1:0]  pp;
  logic [3:0][2*H-1:0]  s2_pp_q, s2_pp_d;

  // S3: extended/lane-packed sum, then accumulate + output register
  logic             s3_vld_q, s3_vld_d;
  logic             s3_last_q, s3_last_d;
  logic             s3_split_q, s3_split_d;
  logic [ACC_W-1:0] s3_sum_q, s3_sum_d;
  logic [ACC_W-1:0] sum_c;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;

  assign advance       = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;

  // Only the first beat of a group decides the mode; later beats reuse it.
  assign beat_mode = in_grp_q ? grp_mode_q : decode_mode(bus.in_mode);

  always_comb begin
    in_grp_d   = in_grp_q;
    grp_mode_d = grp_mode_q;
    s1_ctl_d   = s1_ctl_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    if (accept) begin
      in_grp_d   = !bus.in_last;
      grp_mode_d = beat_mode;
    end
    if (advance) begin
      s1_ctl_d.valid = accept;
      s1_ctl_d.last  = bus.in_last;
      s1_ctl_d.mode  = beat_mode;
      if (accept) begin
        s1_x_d = bus.in_x;
        s1_y_d = bus.in_y;
      end
    end
  end

  // Partial products. In split mode every half is a top half, so the low
  // halves become signed too; in full mode only xH/yH carry a sign.
  logic s1_sg;
  logic s1_lo_sg;

  assign s1_sg    = (s1_ctl_q.mode.sgn == SIGN_S);
  assign s1_lo_sg = s1_sg && (s1_ctl_q.mode.split == MODE_SPLIT);

  mp_hps_mult #(.H(H)) u_pp0 (
    .a(s1_x_q[H-1:0]), .b(s1_y_q[H-1:0]), .a_signed(s1_lo_sg), .b_signed(s1_lo_sg), .p(pp[0])
  );
  mp_hps_mult #(.H(H)) u_pp1 (
    .a(s1_x_q[W-1:H]), .b(s1_y_q[H-1:0]), .a_signed(s1_sg), .b_signed(s1_lo_sg), .p(pp[1])
  );
  mp_hps_mult #(.H(H)) u_pp2 (
    .a(s1_x_q[H-1:0]), .b(s1_y_q[W-1:H]), .a_signed(s1_lo_sg), .b_signed(s1_sg), .p(pp[2])
  );
  mp_hps_mult #(.H(H)) u_pp3 (
    .a(s1_x_q[W-1:H]), .b(s1_y_q[W-1:H]), .a_signed(s1_sg), .b_signed(s1_sg), .p(pp[3])
  );

  always_comb begin
    s2_ctl_d = s2_ctl_q;
    s2_pp_d  = s2_pp_q;
    if (advance) begin
      s2_ctl_d = s1_ctl_q;
      s2_pp_d  = pp;
    end
  end

  // Lane/shift combine. Each partial product is extended with the sign it
  // actually carries: pp0 is unsigned in full mode, the others follow the
  // signed flag. Split lanes extend to half the accumulator width.
  logic             s2_sg;
  logic             s2_sp;
  logic [ACC_W-1:0] e0, e1, e2, e3;
  logic [HA-1:0]    l0, l3;

  always_comb begin
    s2_sg = (s2_ctl_q.mode.sgn == SIGN_S);
    s2_sp = (s2_ctl_q.mode.split == MODE_SPLIT);
    e0 = {ACC_W{s2_sp && s2_sg && s2_pp_q[0][2*H-1]}};
    e0[2*H-1:0] = s2_pp_q[0];
    e1 = {ACC_W{s2_sg && s2_pp_q[1][2*H-1]}};
    e1[2*H-1:0] = s2_pp_q[1];
    e2 = {ACC_W{s2_sg && s2_pp_q[2][2*H-1]}};
    e2[2*H-1:0] = s2_pp_q[2];
    e3 = {ACC_W{s2_sg && s2_pp_q[3][2*H-1]}};
    e3[2*H-1:0] = s2_pp_q[3];
    l0 = {HA{s2_sg && s2_pp_q[0][2*H-1]}};
    l0[2*H-1:0] = s2_pp_q[0];
    l3 = {HA{s2_sg && s2_pp_q[3][2*H-1]}};
    l3[2*H-1:0] = s2_pp_q[3];
    if (s2_sp) begin
      sum_c = {l3, l0};
    end else begin
      sum_c = e0 + (e1 << H) + (e2 << H) + (e3 << W);
    end
  end

  always_comb begin
    s3_vld_d   = s3_vld_q;
    s3_last_d  = s3_last_q;
    s3_split_d = s3_split_q;
    s3_sum_d   = s3_sum_q;
    if (advance) begin
      s3_vld_d   = s2_ctl_q.valid;
      s3_last_d  = s2_ctl_q.last;
      s3_split_d = s2_sp;
      s3_sum_d   = sum_c;
    end
  end

  // Split mode adds the halves independently so no carry crosses lanes.
  always_comb begin
    if (s3_split_q) begin
      acc_sum = {acc_q[ACC_W-1:HA] + s3_sum_q[ACC_W-1:HA],
                 acc_q[HA-1:0] + s3_sum_q[HA-1:0]};
    end else begin
      acc_sum = acc_q + s3_sum_q;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    if (advance) begin
      // A new last result landing on the handshake edge keeps out_valid high.
      out_valid_d = s3_vld_q && s3_last_q;
      if (s3_vld_q) begin
        if (s3_last_q) begin
          out_acc_d = acc_sum;
          acc_d     = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_grp_q    <= 1'b0;
      grp_mode_q  <= '0;
      s1_ctl_q    <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s2_ctl_q    <= '0;
      s2_pp_q     <= '0;
      s3_vld_q    <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_split_q  <= 1'b0;
      s3_sum_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
    end else begin
      in_grp_q    <= in_grp_d;
      grp_mode_q  <= grp_mode_d;
      s1_ctl_q    <= s1_ctl_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s2_ctl_q    <= s2_ctl_d;
      s2_pp_q     <= s2_pp_d;
      s3_vld_q    <= s3_vld_d;
      s3_last_q   <= s3_last_d;
      s3_split_q  <= s3_split_d;
      s3_sum_q    <= s3_sum_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
    end
  end

endmodule

// File: tb/tb_mp_mac_pipe.sv
// Directed self-checking bench for mp_mac_pipe (W=8, ACC_W=32).
// Latency: drives beats after each rising edge, samples on falling edges.
// Backpressure: exercises out_ready stalls and checks in_ready/out_acc hold.
module tb_mp_mac_pipe;

  localparam logic [1:0] M_FU = 2'b00;  // full, unsigned
  localparam logic [1:0] M_FS = 2'b10;  // full, signed
  localparam logic [1:0] M_SU = 2'b01;  // split, unsigned
  localparam logic [1:0] M_SS = 2'b11;  // split, signed

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mp_mac_pipe_if #(.W(8), .ACC_W(32)) bus ();

  mp_mac_pipe #(.W(8), .ACC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [1:0] m, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_mode  = m;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result, check it, let it be consumed.
  task automatic wait_out(input string tag, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.out_acc, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_mode   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_acc", bus.out_acc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: unsigned full, 3 x (255*255), exact 3-cycle latency
    send(8'hFF, 8'hFF, M_FU, 1'b0);
    send(8'hFF, 8'hFF, M_FU, 1'b0);
    send(8'hFF, 8'hFF, M_FU, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t1_not_yet", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    check("t1_vld_at_k3", 32'(bus.out_valid), 32'd1);
    check("t1_acc", bus.out_acc, 32'h0002FA03);
    @(posedge clk);
    #1;

    // 2: signed full, -128 * 127
    send(8'h80, 8'h7F, M_FS, 1'b1);
    wait_out("t2_signed_full", 32'hFFFFC080);

    // 3: signed split, lane0 = 3*5, lane1 = -1*2
    send(8'hF3, 8'h25, M_SS, 1'b1);
    wait_out("t3_signed_split", 32'hFFFE000F);

    // 4: unsigned split, 300 x (15*15) per lane, wraps within each lane
    for (int i = 0; i < 300; i++) begin
      send(8'hFF, 8'hFF, M_SU, (i == 299));
    end
    wait_out("t4_lane_wrap", 32'h07AC07AC);

    // Mode latched on first beat: both beats are signed full (-1*2 each)
    send(8'hFF, 8'h02, M_FS, 1'b0);
    send(8'hFF, 8'h02, M_SU, 1'b1);
    wait_out("t_mode_latch", 32'hFFFFFFFC);

    // 5: backpressure. Group A = 2 x (10*10); group B = 4 x (3*4)
    bus.out_ready = 1'b0;
    send(8'd10, 8'd10, M_FU, 1'b0);
    send(8'd10, 8'd10, M_FU, 1'b1);
    send(8'd3, 8'd4, M_FU, 1'b0);
    send(8'd3, 8'd4, M_FU, 1'b0);
    send(8'd3, 8'd4, M_FU, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_x     = 8'd3;
    bus.in_y     = 8'd4;
    bus.in_mode  = M_FU;
    bus.in_last  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t5_stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("t5_stall_vld", 32'(bus.out_valid), 32'd1);
      check("t5_stall_acc", bus.out_acc, 32'd200);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("t5_vld_drop", 32'(bus.out_valid), 32'd0);
    wait_out("t5_group_b", 32'd48);

    // 6: reset mid-group discards the partial sum
    send(8'd50, 8'd50, M_FU, 1'b0);
    send(8'd50, 8'd50, M_FU, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_vld", 32'(bus.out_valid), 32'd0);
    check("t6_rst_acc", bus.out_acc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(8'd2, 8'd3, M_FU, 1'b1);
    wait_out("t6_after_rst", 32'd6);

    // Back-to-back one-beat groups: out_valid stays high across results
    send(8'd2, 8'd3, M_FU, 1'b1);
    send(8'd4, 8'd5, M_FU, 1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("b2b_vld0", 32'(bus.out_valid), 32'd1);
    check("b2b_acc0", bus.out_acc, 32'd6);
    @(negedge clk);
    check("b2b_vld1", 32'(bus.out_valid), 32'd1);
    check("b2b_acc1", bus.out_acc, 32'd20);
    @(negedge clk);
    check("b2b_idle", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
